rename_alloc_ctrl: RTL and testbench
====================================

Name: rename_alloc_ctrl

Overview:
- Allocation controller and recovery sequencer in front of the physical-register freelist in the rename stage.
- Accepts one 4-lane rename group per cycle from decode and decides whether the group can be granted pregs; drives the freelist `readout_num`.
- Holds up to NUM_CKPT branch checkpoints of the freelist head pointer.
- On branch mispredict or exception flush, sequences the freelist recover pulse and a fixed refill stall.

Parameters:
- PRF_NUM, 128, physical register count; the free pool holds FL_DEPTH = PRF_NUM-32 entries.
- PREG_IDX_W, 7, preg index / pointer width.
- NUM_CKPT, 4, checkpoint slots (power of 2); CK_W = log2(NUM_CKPT).
- RECOVER_CYC, 2, stall cycles after a recover pulse.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dec_valid  in  1  rename group present
- dec_dst_mask  in  4  lanes needing a new preg
- dec_has_branch  in  1  group contains a branch needing a checkpoint
- dec_ready  out  1  group accepted when dec_valid&&dec_ready
- ckpt_alloc_id  out  CK_W  checkpoint id given to the branch in the firing group
- fl_readout_num  out  3  pregs popped from the freelist this cycle
- fl_free_cnt  in  PREG_IDX_W  current freelist occupancy
- fl_commit_cnt  in  3  pregs freed by commit this cycle (forwardable)
- fl_head  in  PREG_IDX_W  current freelist head pointer
- br_resolve_valid  in  1  branch resolved
- br_resolve_id  in  CK_W  its checkpoint id
- br_mispredict  in  1  resolved branch mispredicted
- exc_flush  in  1  exception flush
- exc_head  in  PREG_IDX_W  committed freelist head for flush
- fl_recover_valid  out  1  one-cycle recover pulse to the freelist
- fl_recover_head  out  PREG_IDX_W  head value to restore
- ckpt_full  out  1  all checkpoint slots valid

Behaviour:
- need = popcount(dec_dst_mask), range 0..4.
- room = (fl_free_cnt + fl_commit_cnt >= need), computed at PREG_IDX_W+1 bits.
- dec_ready = (state==RUN) && !exc_flush && !(br_resolve_valid&&br_mispredict) && room && !(dec_has_branch && ckpt_full). All combinational, no dependence on dec_valid.
- fire = dec_valid && dec_ready. fl_readout_num = fire ? need : 0, combinational. The freelist returns indices one cycle later.
- Checkpoints:
  - Circular buffer with per-slot valid bit, snapshot head, ckpt_tail and ckpt_head pointers.
  - On fire with dec_has_branch: slot[ckpt_tail] <= {valid=1, (fl_head+need) mod FL_DEPTH}; ckpt_alloc_id = ckpt_tail; ckpt_tail++.
  - ckpt_full = valid[ckpt_tail].
  - Correct resolve: clear valid[id]. ckpt_head skips invalid slots, at most one step per cycle. A resolve to an invalid id is ignored.
- FSM states: RUN, RECOVER, REFILL. Reset state is RUN.
  - RUN -> RECOVER on exc_flush, or on br_resolve_valid&&br_mispredict with valid[id].
  - Flush priority: exc_flush beats mispredict in the same cycle. It latches exc_head and clears all valid bits; ckpt_tail <= ckpt_head.
  - Mispredict: latches slot[id].head and invalidates id and every younger slot up to ckpt_tail-1; ckpt_tail <= id.
  - RECOVER (1 cycle): fl_recover_valid=1, fl_recover_head=latched value, dec_ready=0 -> REFILL with counter=RECOVER_CYC-1.
  - REFILL: dec_ready=0, counter decrements; at 0 -> RUN.
  - exc_flush arriving in RECOVER/REFILL returns to RECOVER with exc_head. Mispredicts are ignored outside RUN, because a younger-than-flush branch is already dead.
- Simultaneous fire and correct resolve in the same cycle: both take effect. If the resolve frees the tail slot the same cycle, ckpt_full still uses the pre-update state.
- Pointer wrap: all head arithmetic is modulo FL_DEPTH; ckpt pointers wrap mod NUM_CKPT.
- Reset (any state): outputs 0, fl_recover_head 0, all valid bits 0, pointers 0, state RUN. Reset mid-RECOVER produces no pulse on the following cycle.

Optional Feature:
RENAME_ALLOC_STATS_EN:
- Compiled in: adds 32-bit outputs stall_preg_cnt (dec_valid && RUN && !room) and stall_ckpt_cnt (dec_valid && RUN && room && dec_has_branch && ckpt_full). Both saturate at all-ones and reset to 0.
- Compiled out: neither port nor counter exists.

Decomposition:
- Shared rename package: PRF_NUM, FL_DEPTH, PREG_IDX_W, NUM_CKPT, the state enum {RUN,RECOVER,REFILL}, and the ckpt_entry_t struct {valid, head}.
- One natural sub-module, rename_ckpt_buf: checkpoint storage, pointer/valid management, alloc/free/squash. The FSM and allocation gating stay in the top module.

Test Plan:
- Free=96, mask=1111 for 3 cycles -> dec_ready=1 each cycle, fl_readout_num=4, ckpt untouched.
- fl_free_cnt=1, fl_commit_cnt=2, mask=1011 -> dec_ready=1, readout_num=3. Then commit_cnt=1 -> dec_ready=0, readout_num=0.
- Four branch groups fire (ids 0..3) -> ckpt_full=1; fifth branch group stalls. Resolve id 0 correct -> next cycle dec_ready=1, id=0 reused.
- fl_head=95, need=2 on a branch fire -> snapshot=1 (wrap). Mispredict id -> fl_recover_valid pulses 1 cycle, head=1, then dec_ready=0 for 2 cycles, younger ids invalid.
- Mispredict and exc_flush same cycle with exc_head=40 -> recover_head=40, all checkpoints cleared.
- rst asserted during REFILL -> next cycle state RUN, outputs 0, no recover pulse.

Source files
------------

// File: rtl/rename_alloc_ctrl_pkg.sv
// Shared rename types/constants: freelist geometry, checkpoint slot layout, recovery FSM states.
// Head arithmetic helpers wrap modulo FL_DEPTH.
package rename_alloc_ctrl_pkg;

  localparam int PRF_NUM     = 128;
  localparam int FL_DEPTH    = PRF_NUM - 32;
  localparam int PREG_IDX_W  = 7;
  localparam int NUM_CKPT    = 4;
  localparam int CK_W        = $clog2(NUM_CKPT);
  localparam int RECOVER_CYC = 2;
  localparam int CNT_W       = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

  localparam logic [PREG_IDX_W:0] FL_DEPTH_W  = (PREG_IDX_W+1)'(FL_DEPTH);
  localparam logic [CNT_W-1:0]    REFILL_INIT = CNT_W'(RECOVER_CYC - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RECOVER = 2'd1,
    REFILL  = 2'd2
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic [PREG_IDX_W-1:0] head;
  } ckpt_entry_t;

  function automatic logic [2:0] popcnt4(input logic [3:0] m);
    popcnt4 = 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

  // Inputs are always < FL_DEPTH, so one conditional subtract is enough.
  function automatic logic [PREG_IDX_W-1:0] head_add(input logic [PREG_IDX_W-1:0] h,
                                                     input logic [2:0]            n);
    logic [PREG_IDX_W:0] s;
    s = {1'b0, h} + (PREG_IDX_W+1)'(n);
    if (s >= FL_DEPTH_W) s = s - FL_DEPTH_W;
    return s[PREG_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/rename_ckpt_buf.sv
// Circular checkpoint buffer of freelist heads: alloc at tail, free on resolve, squash younger on mispredict, clear on flush.
// Single-cycle update; full_o and lookups reflect registered (pre-update) state.
module rename_ckpt_buf
  import rename_alloc_ctrl_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alloc_i,
  input  logic [PREG_IDX_W-1:0] alloc_head_i,
  output logic [CK_W-1:0]       alloc_id_o,
  output logic                  full_o,
  input  logic                  resolve_i,
  input  logic [CK_W-1:0]       resolve_id_i,
  input  logic                  squash_i,
  input  logic                  flush_i,
  output logic                  id_vld_o,
  output logic [PREG_IDX_W-1:0] id_head_o
);

  ckpt_entry_t         slot_q [NUM_CKPT];
  ckpt_entry_t         slot_d [NUM_CKPT];
  logic [CK_W-1:0]     tail_q, tail_d;
  logic [CK_W-1:0]     head_q, head_d;
  logic [NUM_CKPT-1:0] vld;
  logic [CK_W-1:0]     span;
  logic [CK_W-1:0]     off;

  always_comb begin
    vld = '0;
    for (int i = 0; i < NUM_CKPT; i++) vld[i] = slot_q[i].valid;
  end

  assign alloc_id_o = tail_q;
  assign full_o     = slot_q[tail_q].valid;
  assign id_vld_o   = slot_q[resolve_id_i].valid;
  assign id_head_o  = slot_q[resolve_id_i].head;
  // Distance from squashed id to tail; zero means the buffer is full and everything from id on dies.
  assign span       = tail_q - resolve_id_i;

  always_comb begin
    slot_d = slot_q;
    tail_d = tail_q;
    head_d = head_q;
    off    = '0;
    if (flush_i) begin
      for (int i = 0; i < NUM_CKPT; i++) slot_d[i].valid = 1'b0;
      tail_d = head_q;
    end else begin
      if (squash_i) begin
        for (int i = 0; i < NUM_CKPT; i++) begin
          off = CK_W'(i) - resolve_id_i;
          if (span == '0 || off < span) slot_d[i].valid = 1'b0;
        end
        tail_d = resolve_id_i;
      end else begin
        if (resolve_i && slot_q[resolve_id_i].valid) slot_d[resolve_id_i].valid = 1'b0;
        if (alloc_i) begin
          slot_d[tail_q].valid = 1'b1;
          slot_d[tail_q].head  = alloc_head_i;
          tail_d               = tail_q + CK_W'(1);
        end
      end
      // Oldest pointer walks past freed slots one per cycle; head==tail with no valid slot is empty.
      if (!slot_q[head_q].valid && (head_q != tail_q || |vld)) head_d = head_q + CK_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CKPT; i++) slot_q[i] <= '0;
      tail_q <= '0;
      head_q <= '0;
    end else begin
      slot_q <= slot_d;
      tail_q <= tail_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/rename_alloc_ctrl.sv
// Rename alloc gating (combinational grant/readout) plus flush/mispredict recovery: 1-cycle recover pulse, then RECOVER_CYC stall.
// dec_ready drops on no preg room, full checkpoints with a branch, or recovery. RENAME_ALLOC_STATS_EN adds saturating stall counters.
module rename_alloc_ctrl
  import rename_alloc_ctrl_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dec_valid_i,
  input  logic [3:0]            dec_dst_mask_i,
  input  logic                  dec_has_branch_i,
  output logic                  dec_ready_o,
  output logic [CK_W-1:0]       ckpt_alloc_id_o,
  output logic [2:0]            fl_readout_num_o,
  input  logic [PREG_IDX_W-1:0] fl_free_cnt_i,
  input  logic [2:0]            fl_commit_cnt_i,
  input  logic [PREG_IDX_W-1:0] fl_head_i,
  input  logic                  br_resolve_valid_i,
  input  logic [CK_W-1:0]       br_resolve_id_i,
  input  logic                  br_mispredict_i,
  input  logic                  exc_flush_i,
  input  logic [PREG_IDX_W-1:0] exc_head_i,
  output logic                  fl_recover_valid_o,
  output logic [PREG_IDX_W-1:0] fl_recover_head_o,
`ifdef RENAME_ALLOC_STATS_EN
  output logic [31:0]           stall_preg_cnt_o,
  output logic [31:0]           stall_ckpt_cnt_o,
  output logic                  ckpt_full_o
`else
  output logic                  ckpt_full_o
`endif
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PREG_IDX_W-1:0] rec_head_q, rec_head_d;

  logic [2:0]            need;
  logic [PREG_IDX_W:0]   avail;
  logic                  room;
  logic                  mispredict;
  logic                  fire;
  logic                  squash;
  logic                  id_vld;
  logic [PREG_IDX_W-1:0] id_head;

  assign need       = popcnt4(dec_dst_mask_i);
  assign avail      = {1'b0, fl_free_cnt_i} + (PREG_IDX_W+1)'(fl_commit_cnt_i);
  assign room       = avail >= (PREG_IDX_W+1)'(need);
  assign mispredict = br_resolve_valid_i && br_mispredict_i;
  assign fire       = dec_valid_i && dec_ready_o;
  assign squash     = (state_q == RUN) && !exc_flush_i && mispredict && id_vld;

  rename_ckpt_buf u_ckpt_buf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .alloc_i      (fire && dec_has_branch_i),
    .alloc_head_i (head_add(fl_head_i, need)),
    .alloc_id_o   (ckpt_alloc_id_o),
    .full_o       (ckpt_full_o),
    .resolve_i    (br_resolve_valid_i && !br_mispredict_i),
    .resolve_id_i (br_resolve_id_i),
    .squash_i     (squash),
    .flush_i      (exc_flush_i),
    .id_vld_o     (id_vld),
    .id_head_o    (id_head)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      rec_head_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rec_head_q <= rec_head_d;
    end
  end

  // Flush always wins; mispredicts only count while running since anything younger than a flush is dead.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rec_head_d = rec_head_q;
    if (exc_flush_i) begin
      state_d    = RECOVER;
      rec_head_d = exc_head_i;
    end else begin
      case (state_q)
        RUN: begin
          if (squash) begin
            state_d    = RECOVER;
            rec_head_d = id_head;
          end
        end
        RECOVER: begin
          state_d = REFILL;
          cnt_d   = REFILL_INIT;
        end
        REFILL: begin
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    dec_ready_o        = 1'b0;
    fl_recover_valid_o = 1'b0;
    fl_recover_head_o  = rec_head_q;
    if (!rst_i) begin
      fl_recover_valid_o = (state_q == RECOVER);
      dec_ready_o        = (state_q == RUN) && !exc_flush_i && !mispredict && room &&
                           !(dec_has_branch_i && ckpt_full_o);
    end
  end

  assign fl_readout_num_o = fire ? need : 3'd0;

`ifdef RENAME_ALLOC_STATS_EN
  logic [31:0] stall_preg_q;
  logic [31:0] stall_ckpt_q;
  logic        stall_preg_ev;
  logic        stall_ckpt_ev;

  assign stall_preg_ev = dec_valid_i && (state_q == RUN) && !room;
  assign stall_ckpt_ev = dec_valid_i && (state_q == RUN) && room && dec_has_branch_i && ckpt_full_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_preg_q <= '0;
      stall_ckpt_q <= '0;
    end else begin
      if (stall_preg_ev && !(&stall_preg_q)) stall_preg_q <= stall_preg_q + 32'd1;
      if (stall_ckpt_ev && !(&stall_ckpt_q)) stall_ckpt_q <= stall_ckpt_q + 32'd1;
    end
  end

  assign stall_preg_cnt_o = stall_preg_q;
  assign stall_ckpt_cnt_o = stall_ckpt_q;
`endif

endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// Directed bench for rename_alloc_ctrl: per-cycle expectations queued by the stimulus, checked by a negedge monitor.
module tb_rename_alloc_ctrl;
  import rename_alloc_ctrl_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  dec_valid;
  logic [3:0]            dec_dst_mask;
  logic                  dec_has_branch;
  logic                  dec_ready;
  logic [CK_W-1:0]       ckpt_alloc_id;
  logic [2:0]            fl_readout_num;
  logic [PREG_IDX_W-1:0] fl_free_cnt;
  logic [2:0]            fl_commit_cnt;
  logic [PREG_IDX_W-1:0] fl_head;
  logic                  br_resolve_valid;
  logic [CK_W-1:0]       br_resolve_id;
  logic                  br_mispredict;
  logic                  exc_flush;
  logic [PREG_IDX_W-1:0] exc_head;
  logic                  fl_recover_valid;
  logic [PREG_IDX_W-1:0] fl_recover_head;
  logic                  ckpt_full;
`ifdef RENAME_ALLOC_STATS_EN
  logic [31:0]           stall_preg_cnt;
  logic [31:0]           stall_ckpt_cnt;
`endif

  always #5 clk = ~clk;

  rename_alloc_ctrl dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .dec_valid_i        (dec_valid),
    .dec_dst_mask_i     (dec_dst_mask),
    .dec_has_branch_i   (dec_has_branch),
    .dec_ready_o        (dec_ready),
    .ckpt_alloc_id_o    (ckpt_alloc_id),
    .fl_readout_num_o   (fl_readout_num),
    .fl_free_cnt_i      (fl_free_cnt),
    .fl_commit_cnt_i    (fl_commit_cnt),
    .fl_head_i          (fl_head),
    .br_resolve_valid_i (br_resolve_valid),
    .br_resolve_id_i    (br_resolve_id),
    .br_mispredict_i    (br_mispredict),
    .exc_flush_i        (exc_flush),
    .exc_head_i         (exc_head),
    .fl_recover_valid_o (fl_recover_valid),
    .fl_recover_head_o  (fl_recover_head),
`ifdef RENAME_ALLOC_STATS_EN
    .stall_preg_cnt_o   (stall_preg_cnt),
    .stall_ckpt_cnt_o   (stall_ckpt_cnt),
`endif
    .ckpt_full_o        (ckpt_full)
  );

  typedef struct {
    int tag;
    bit rdy;
    int num;
    bit full;
    bit rec;
    int rh;
    int id;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   tag    = 0;

  task automatic check(input string nm, input int t, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s step%0d: got %0d expected %0d", nm, t, act, exp);
  endtask

  // Monitor: one expectation record per stimulus cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("dec_ready", e.tag, int'(dec_ready), int'(e.rdy));
        check("readout_num", e.tag, int'(fl_readout_num), e.num);
        check("ckpt_full", e.tag, int'(ckpt_full), int'(e.full));
        check("recover_valid", e.tag, int'(fl_recover_valid), int'(e.rec));
        if (e.rec) check("recover_head", e.tag, int'(fl_recover_head), e.rh);
        if (e.id >= 0) check("alloc_id", e.tag, int'(ckpt_alloc_id), e.id);
      end
    end
  end

  task automatic idle();
    dec_valid        = 1'b0;
    dec_dst_mask     = 4'b0000;
    dec_has_branch   = 1'b0;
    fl_free_cnt      = 7'd96;
    fl_commit_cnt    = 3'd0;
    fl_head          = 7'd0;
    br_resolve_valid = 1'b0;
    br_resolve_id    = '0;
    br_mispredict    = 1'b0;
    exc_flush        = 1'b0;
    exc_head         = 7'd0;
  endtask

  task automatic grp(input logic [3:0] mask, input logic br, input int head);
    dec_valid      = 1'b1;
    dec_dst_mask   = mask;
    dec_has_branch = br;
    fl_head        = 7'(head);
  endtask

  task automatic resolve(input int id, input logic mp);
    br_resolve_valid = 1'b1;
    br_resolve_id    = CK_W'(id);
    br_mispredict    = mp;
  endtask

  task automatic step(input bit rdy, input int num, input bit full, input bit rec, input int rh, input int id);
    exp_t e;
    e.tag = tag; e.rdy = rdy; e.num = num; e.full = full; e.rec = rec; e.rh = rh; e.id = id;
    sb_q.push_back(e);
    tag++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // In reset: grant suppressed even with a valid group and room
    idle(); grp(4'b1111, 1'b0, 0);                   step(0, 0, 0, 0, 0, -1);
    rst = 1'b0;

    // Plenty of room, full groups
    for (int i = 0; i < 3; i++) begin
      idle(); grp(4'b1111, 1'b0, 0);                 step(1, 4, 0, 0, 0, -1);
    end
    // Commit forwarding makes just enough room, then one short
    idle(); grp(4'b1011, 1'b0, 0); fl_free_cnt = 7'd1; fl_commit_cnt = 3'd2; step(1, 3, 0, 0, 0, -1);
    idle(); grp(4'b1011, 1'b0, 0); fl_free_cnt = 7'd1; fl_commit_cnt = 3'd1; step(0, 0, 0, 0, 0, -1);
    idle(); grp(4'b0000, 1'b0, 0); fl_free_cnt = 7'd0;                       step(1, 0, 0, 0, 0, -1);

    // Fill all checkpoints, fifth branch stalls, free id 0 and reuse it
    for (int i = 0; i < 4; i++) begin
      idle(); grp(4'b0001, 1'b1, 10);                step(1, 1, 0, 0, 0, i);
    end
    idle(); grp(4'b0001, 1'b1, 10);                  step(0, 0, 1, 0, 0, -1);
    idle(); resolve(0, 1'b0);                        step(1, 0, 1, 0, 0, -1);
    idle(); grp(4'b0011, 1'b1, 10);                  step(1, 2, 0, 0, 0, 0);
    // Drain: tail=1, full stays until slot 1 frees
    idle(); resolve(1, 1'b0);                        step(1, 0, 1, 0, 0, -1);
    idle(); resolve(2, 1'b0);                        step(1, 0, 0, 0, 0, -1);
    idle(); resolve(3, 1'b0);                        step(1, 0, 0, 0, 0, -1);
    idle(); resolve(0, 1'b0);                        step(1, 0, 0, 0, 0, -1);
    idle();                                          step(1, 0, 0, 0, 0, -1);
    // Mispredict to an invalid id: stalls that cycle only, no recovery
    idle(); resolve(2, 1'b1);                        step(0, 0, 0, 0, 0, -1);
    idle(); grp(4'b0001, 1'b0, 0);                   step(1, 1, 0, 0, 0, -1);

    // Snapshot wraps: 95+2 mod 96 = 1, then mispredict id 1
    idle(); grp(4'b0011, 1'b1, 95);                  step(1, 2, 0, 0, 0, 1);
    idle(); grp(4'b0001, 1'b1, 50);                  step(1, 1, 0, 0, 0, 2);
    idle(); grp(4'b0001, 1'b0, 0); resolve(1, 1'b1); step(0, 0, 0, 0, 0, -1);
    idle(); grp(4'b0001, 1'b0, 0);                   step(0, 0, 0, 1, 1, -1);
    idle(); grp(4'b0001, 1'b0, 0);                   step(0, 0, 0, 0, 0, -1);
    idle(); grp(4'b0001, 1'b0, 0);                   step(0, 0, 0, 0, 0, -1);
    idle(); grp(4'b0001, 1'b1, 20);                  step(1, 1, 0, 0, 0, 1);
    // Younger id 2 was squashed: its mispredict does nothing
    idle(); resolve(2, 1'b1);                        step(0, 0, 0, 0, 0, -1);
    idle();                                          step(1, 0, 0, 0, 0, -1);

    // Flush beats a same-cycle mispredict
    idle(); grp(4'b0001, 1'b0, 0); resolve(1, 1'b1); exc_flush = 1'b1; exc_head = 7'd40; step(0, 0, 0, 0, 0, -1);
    idle(); grp(4'b0001, 1'b0, 0);                   step(0, 0, 0, 1, 40, -1);
    idle(); grp(4'b0001, 1'b0, 0);                   step(0, 0, 0, 0, 0, -1);
    idle(); grp(4'b0001, 1'b0, 0);                   step(0, 0, 0, 0, 0, -1);
    idle(); resolve(1, 1'b1);                        step(0, 0, 0, 0, 0, -1);
    idle(); grp(4'b0000, 1'b1, 0);                   step(1, 0, 0, 0, 0, 1);

    // Flush during REFILL restarts recovery; reset in REFILL aborts it
    idle(); exc_flush = 1'b1; exc_head = 7'd33;      step(0, 0, 0, 0, 0, -1);
    idle();                                          step(0, 0, 0, 1, 33, -1);
    idle(); exc_flush = 1'b1; exc_head = 7'd70;      step(0, 0, 0, 0, 0, -1);
    idle();                                          step(0, 0, 0, 1, 70, -1);
    idle(); rst = 1'b1; grp(4'b1111, 1'b0, 0);       step(0, 0, 0, 0, 0, -1);
    rst = 1'b0;
    idle(); grp(4'b1111, 1'b0, 0);                   step(1, 4, 0, 0, 0, -1);
    idle();                                          step(1, 0, 0, 0, 0, -1);

    repeat (2) @(negedge clk);
    n_chk++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
